// File: rtl/regfile_dump_ctrl.sv
// Read-side dump engine for the 32x32 register file: sweeps an inclusive register
// range two registers per access and streams the words out over valid/ready.
module regfile_dump_ctrl #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [ADDR_W-1:0] FirstReg,
    input  logic [ADDR_W-1:0] LastReg,
    output logic [ADDR_W-1:0] ReadRegister1,
    output logic [ADDR_W-1:0] ReadRegister2,
    input  logic [DATA_W-1:0] ReadData1,
    input  logic [DATA_W-1:0] ReadData2,
    output logic [DATA_W-1:0] DumpData,
    output logic [ADDR_W-1:0] DumpIndex,
    output logic              DumpValid,
    input  logic              DumpReady,
    output logic              Busy,
    output logic              Done,
    output logic [2:0]        DbgState
);

    // Stream handshake: a word moves on a rising edge with DumpValid && DumpReady;
    // while stalled, DumpData/DumpIndex hold and DumpValid stays up until taken.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        SEND0 = 3'd2,
        SEND1 = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] ptr, last;
    logic [DATA_W-1:0] buf0, buf1;

    // One extra bit so ptr+1/ptr+2 compare correctly at the top of the index space.
    logic [ADDR_W:0] ptr_p1, ptr_p2, last_x, rr2_full;

    assign ptr_p1   = {1'b0, ptr} + (ADDR_W+1)'(1);
    assign ptr_p2   = {1'b0, ptr} + (ADDR_W+1)'(2);
    assign last_x   = {1'b0, last};
    assign rr2_full = ptr_p1 % (ADDR_W+1)'(NUM_REGS);

    assign ReadRegister1 = ptr;
    assign ReadRegister2 = rr2_full[ADDR_W-1:0];
    assign DbgState      = state;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr  <= '0;
            last <= '0;
            buf0 <= '0;
            buf1 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start && (FirstReg <= LastReg)) begin
                        ptr  <= FirstReg;
                        last <= LastReg;
                    end
                end
                READ: begin
                    buf0 <= ReadData1;
                    buf1 <= ReadData2;
                end
                SEND1: begin
                    if (DumpReady && (ptr_p2 <= last_x)) begin
                        ptr <= ptr_p2[ADDR_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        DumpData   = '0;
        DumpIndex  = '0;
        DumpValid  = 1'b0;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_next = (FirstReg <= LastReg) ? READ : DONE;
                end
            end
            READ: begin
                Busy       = 1'b1;
                state_next = SEND0;
            end
            SEND0: begin
                Busy      = 1'b1;
                DumpValid = 1'b1;
                DumpData  = buf0;
                DumpIndex = ptr;
                if (DumpReady) begin
                    state_next = (ptr_p1 <= last_x) ? SEND1 : DONE;
                end
            end
            SEND1: begin
                Busy      = 1'b1;
                DumpValid = 1'b1;
                DumpData  = buf1;
                DumpIndex = ptr_p1[ADDR_W-1:0];
                if (DumpReady) begin
                    state_next = (ptr_p2 <= last_x) ? READ : DONE;
                end
            end
            DONE: begin
                Done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
